// File: rtl/median3x3_scan_if.sv
// rtl/median3x3_scan_if.sv - image-store read bus and filtered pixel stream of median3x3_scan
interface median3x3_scan_if;
  logic       rd_en;
  logic [7:0] rd_x;
  logic [7:0] rd_y;
  logic       rd_data;
  logic       pix_valid;
  logic [7:0] pix_x;
  logic [7:0] pix_y;
  logic       pix_out;

  modport master (
    output rd_en, rd_x, rd_y, pix_valid, pix_x, pix_y, pix_out,
    input  rd_data
  );

  modport slave (
    input  rd_en, rd_x, rd_y, pix_valid, pix_x, pix_y, pix_out,
    output rd_data
  );
endinterface

// File: rtl/median3x3_scan.sv
// rtl/median3x3_scan.sv - raster scan of the padded event image with a 3x3 binary majority filter
// Optional MEDIAN3X3_BYPASS_EN adds i_bypass, which passes the window centre through unfiltered.
module median3x3_scan #(
  parameter int unsigned IMWIDTH  = 240,
  parameter int unsigned IMHEIGHT = 180,
  parameter int unsigned THRESH   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
`ifdef MEDIAN3X3_BYPASS_EN
  input  logic             i_bypass,
`endif
  output logic             o_busy,
  output logic             o_done,
  median3x3_scan_if.master bus
);
  localparam int unsigned PW    = IMWIDTH + 2;
  localparam int          XW    = $clog2(PW);
  localparam logic [7:0]  XLAST = 8'(IMWIDTH + 1);
  localparam logic [7:0]  YLAST = 8'(IMHEIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_drain;
  logic [7:0]      r_x;
  logic [7:0]      r_y;
  logic            w_last;
  logic            w_rd_en;
  logic            r_cap_en;
  logic [7:0]      r_cap_x;
  logic [7:0]      r_cap_y;
  logic [XW-1:0]   w_lx;
  logic [PW-1:0]   r_lb0;
  logic [PW-1:0]   r_lb1;
  logic [5:0]      r_win;
  logic [2:0]      w_col;
  logic [8:0]      w_win;
  logic [3:0]      w_cnt;
  logic            w_thr;
  logic            w_pix;
  logic            w_emit;
  logic            r_pix_valid;
  logic [7:0]      r_pix_x;
  logic [7:0]      r_pix_y;
  logic            r_pix_out;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  assign w_last = (r_x == XLAST) && (r_y == YLAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_SCAN;
      S_SCAN:  if (w_last)  w_next = S_DRAIN;
      S_DRAIN: if (r_drain) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rd_en = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      S_SCAN:  begin w_rd_en = 1'b1; o_busy = 1'b1; end
      S_DRAIN: o_busy = 1'b1;
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Address counters sit at 0 outside SCAN so address 0 is issued on the first SCAN cycle.
  always_ff @(posedge clk) begin
    if (reset || r_state != S_SCAN) begin
      r_x <= 8'd0;
      r_y <= 8'd0;
    end else if (r_x == XLAST) begin
      r_x <= 8'd0;
      r_y <= (r_y == YLAST) ? 8'd0 : r_y + 8'd1;
    end else begin
      r_x <= r_x + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_drain <= 1'b0;
    else       r_drain <= (r_state == S_DRAIN) && !r_drain;
  end

  assign bus.rd_en = w_rd_en;
  assign bus.rd_x  = r_x;
  assign bus.rd_y  = r_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cap_en <= 1'b0;
      r_cap_x  <= 8'd0;
      r_cap_y  <= 8'd0;
    end else begin
      r_cap_en <= w_rd_en;
      r_cap_x  <= r_x;
      r_cap_y  <= r_y;
    end
  end

  // r_win keeps the two older columns; the right column is built from the current capture.
  assign w_lx  = r_cap_x[XW-1:0];
  assign w_col = {r_lb1[w_lx], r_lb0[w_lx], bus.rd_data};
  assign w_win = {r_win, w_col};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lb0 <= '0;
      r_lb1 <= '0;
      r_win <= '0;
    end else if (r_cap_en) begin
      r_win       <= w_win[5:0];
      r_lb1[w_lx] <= r_lb0[w_lx];
      r_lb0[w_lx] <= bus.rd_data;
    end
  end

  always_comb begin
    w_cnt = 4'd0;
    for (int i = 0; i < 9; i++) w_cnt = w_cnt + {3'd0, w_win[i]};
  end

  assign w_thr = (32'(w_cnt) + 32'd1) > THRESH;

`ifdef MEDIAN3X3_BYPASS_EN
  assign w_pix = i_bypass ? w_win[4] : w_thr;
`else
  assign w_pix = w_thr;
`endif

  assign w_emit = r_cap_en && (r_cap_x >= 8'd2) && (r_cap_y >= 8'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pix_valid <= 1'b0;
      r_pix_x     <= 8'd0;
      r_pix_y     <= 8'd0;
      r_pix_out   <= 1'b0;
    end else begin
      r_pix_valid <= w_emit;
      if (w_emit) begin
        r_pix_x   <= r_cap_x - 8'd2;
        r_pix_y   <= r_cap_y - 8'd2;
        r_pix_out <= w_pix;
      end
    end
  end

  assign bus.pix_valid = r_pix_valid;
  assign bus.pix_x     = r_pix_x;
  assign bus.pix_y     = r_pix_y;
  assign bus.pix_out   = r_pix_out;
endmodule

// File: tb/tb_median3x3_scan.sv
// tb/tb_median3x3_scan.sv - self-checking bench for median3x3_scan on a reduced 16x12 frame
// Three instances share one store: THRESH=5, THRESH=0 and THRESH=10.
module tb_median3x3_scan;
  localparam int W  = 16;
  localparam int H  = 12;
  localparam int PW = W + 2;
  localparam int PH = H + 2;
  localparam int N  = PW * PH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
`ifdef MEDIAN3X3_BYPASS_EN
  logic bypass = 1'b0;
`endif
  logic busy0, done0, busy1, done1, busy2, done2;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  median3x3_scan_if b0();
  median3x3_scan_if b1();
  median3x3_scan_if b2();

  median3x3_scan #(.IMWIDTH(W), .IMHEIGHT(H), .THRESH(5)) dut (
    .clk(clk), .reset(reset), .i_start(start),
`ifdef MEDIAN3X3_BYPASS_EN
    .i_bypass(bypass),
`endif
    .o_busy(busy0), .o_done(done0), .bus(b0));

  median3x3_scan #(.IMWIDTH(W), .IMHEIGHT(H), .THRESH(0)) dut_t0 (
    .clk(clk), .reset(reset), .i_start(start),
`ifdef MEDIAN3X3_BYPASS_EN
    .i_bypass(bypass),
`endif
    .o_busy(busy1), .o_done(done1), .bus(b1));

  median3x3_scan #(.IMWIDTH(W), .IMHEIGHT(H), .THRESH(10)) dut_t10 (
    .clk(clk), .reset(reset), .i_start(start),
`ifdef MEDIAN3X3_BYPASS_EN
    .i_bypass(bypass),
`endif
    .o_busy(busy2), .o_done(done2), .bus(b2));

  bit mem [PH][PW];

  always @(posedge clk) begin
    b0.rd_data <= b0.rd_en ? mem[b0.rd_y][b0.rd_x] : 1'b0;
    b1.rd_data <= b1.rd_en ? mem[b1.rd_y][b1.rd_x] : 1'b0;
    b2.rd_data <= b2.rd_en ? mem[b2.rd_y][b2.rd_x] : 1'b0;
  end

  int n_vec = 0;
  int n_miss = 0;
  int npix, orderr, rd_cnt, first_rd, a22, first_pix, last_pix;
  int done_cnt, done_cyc, ex, ey, start_cyc;
  int t0_ones, t0_n, t10_ones, t10_n;
  bit busy_at_done;
  bit got  [H][W];
  bit gotv [H][W];

  typedef struct { int pat; int exp_ones; int mid_start; bit sid; } frame_t;
  typedef struct { int pat; int x; int y; bit exp; } spot_t;
  frame_t ft [6];
  spot_t  st [14];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    npix = 0; orderr = 0; rd_cnt = 0; first_rd = -1; a22 = -1; first_pix = -1;
    last_pix = -1; done_cnt = 0; done_cyc = -1; ex = 0; ey = 0; busy_at_done = 1'b1;
    t0_ones = 0; t0_n = 0; t10_ones = 0; t10_n = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        got[y][x] = 1'b0;
        gotv[y][x] = 1'b0;
      end
  endtask

  initial forever begin
    @(negedge clk);
    if (b0.rd_en) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
      if (b0.rd_x == 8'd2 && b0.rd_y == 8'd2) a22 = cyc;
    end
    if (b0.pix_valid) begin
      if (first_pix < 0) first_pix = cyc;
      if (int'(b0.pix_x) != ex || int'(b0.pix_y) != ey || (ex != 0 && cyc != last_pix + 1)) orderr++;
      if (int'(b0.pix_x) < W && int'(b0.pix_y) < H) begin
        got[b0.pix_y][b0.pix_x]  = b0.pix_out;
        gotv[b0.pix_y][b0.pix_x] = 1'b1;
      end
      last_pix = cyc;
      npix++;
      ex++;
      if (ex == W) begin ex = 0; ey++; end
    end
    if (done0) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy0;
    end
    if (b1.pix_valid) begin t0_n++;  t0_ones  += int'(b1.pix_out); end
    if (b2.pix_valid) begin t10_n++; t10_ones += int'(b2.pix_out); end
  end

  task automatic load(input int pat);
    for (int y = 0; y < PH; y++)
      for (int x = 0; x < PW; x++)
        case (pat)
          0:       mem[y][x] = 1'b0;
          1:       mem[y][x] = (x == 5 && y == 4);
          2:       mem[y][x] = (x >= 5 && x <= 7 && y >= 5 && y <= 7);
          3:       mem[y][x] = (x >= 1 && x <= W && y >= 1 && y <= H);
          default: mem[y][x] = 1'($urandom_range(0, 1));
        endcase
  endtask

  // Median of a binary 3x3 neighbourhood: majority of the nine padded cells around the centre.
  function automatic bit model(input int x, input int y, input bit byp);
    int s = 0;
    if (byp) return mem[y + 1][x + 1];
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++)
        s += int'(mem[y + dy][x + dx]);
    return s >= 5;
  endfunction

  task automatic run_frame(input int mid_start, input bit sid, input bit byp, input string tag);
    bit seen = 1'b0;
    int mis = 0;
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    for (int i = 0; i < N + 20 && !seen; i++) begin
      @(negedge clk);
      start = (i == mid_start);
      if (done0) begin
        seen = 1'b1;
        start = sid;
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (!gotv[y][x] || got[y][x] != model(x, y, byp)) mis++;
    check($sformatf("%s done_seen", tag), int'(seen), 1);
    check($sformatf("%s pix_count", tag), npix, W * H);
    check($sformatf("%s raster_order", tag), orderr, 0);
    check($sformatf("%s pixel_errors", tag), mis, 0);
    check($sformatf("%s done_count", tag), done_cnt, 1);
    check($sformatf("%s done_latency", tag), done_cyc - start_cyc, N + 3);
    check($sformatf("%s done_after_last", tag), done_cyc - last_pix, 1);
    check($sformatf("%s busy_at_done", tag), int'(busy_at_done), 0);
    check($sformatf("%s first_addr_latency", tag), first_rd - start_cyc, 1);
    check($sformatf("%s rd_count", tag), rd_cnt, N);
    check($sformatf("%s pix_latency", tag), first_pix - a22, 2);
    check($sformatf("%s busy_after", tag), int'(busy0), 0);
    if (!byp) begin
      check($sformatf("%s thresh0_ones", tag), t0_ones, W * H);
      check($sformatf("%s thresh10_count", tag), t10_n, W * H);
      check($sformatf("%s thresh10_ones", tag), t10_ones, 0);
    end
  endtask

  initial begin
    int ones;
    ft[0] = '{0, 0, -1, 1'b0};
    ft[1] = '{1, 0, -1, 1'b0};
    ft[2] = '{2, 5, -1, 1'b0};
    ft[3] = '{3, W * H - 4, 50, 1'b1};
    ft[4] = '{4, -1, 120, 1'b1};
    ft[5] = '{4, -1, -1, 1'b0};
    st[0]  = '{2, 5, 5, 1'b1};
    st[1]  = '{2, 4, 5, 1'b1};
    st[2]  = '{2, 6, 5, 1'b1};
    st[3]  = '{2, 5, 4, 1'b1};
    st[4]  = '{2, 5, 6, 1'b1};
    st[5]  = '{2, 4, 4, 1'b0};
    st[6]  = '{2, 6, 6, 1'b0};
    st[7]  = '{3, 0, 0, 1'b0};
    st[8]  = '{3, W - 1, 0, 1'b0};
    st[9]  = '{3, 0, H - 1, 1'b0};
    st[10] = '{3, W - 1, H - 1, 1'b0};
    st[11] = '{3, 1, 0, 1'b1};
    st[12] = '{3, 0, 5, 1'b1};
    st[13] = '{3, 7, 7, 1'b1};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", int'(busy0), 0);
    check("reset done", int'(done0), 0);
    check("reset rd_en", int'(b0.rd_en), 0);
    check("reset rd_xy", int'({b0.rd_x, b0.rd_y}), 0);
    check("reset pix", int'({b0.pix_valid, b0.pix_out, b0.pix_x, b0.pix_y}), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      load(ft[i].pat);
      run_frame(ft[i].mid_start, ft[i].sid, 1'b0, $sformatf("frame%0d", i));
      ones = 0;
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) ones += int'(got[y][x]);
      if (ft[i].exp_ones >= 0) check($sformatf("frame%0d ones", i), ones, ft[i].exp_ones);
      for (int j = 0; j < 14; j++)
        if (st[j].pat == ft[i].pat)
          check($sformatf("spot p%0d (%0d,%0d)", st[j].pat, st[j].x, st[j].y),
                int'(got[st[j].y][st[j].x]), int'(st[j].exp));
    end

    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("reset_vs_start busy", int'(busy0), 0);
    check("reset_vs_start rd_en", int'(b0.rd_en), 0);
    @(negedge clk);
    check("reset_vs_start busy_next", int'(busy0), 0);

    load(4);
    clear_mon();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("midscan busy_before", int'(busy0), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midscan busy", int'(busy0), 0);
    check("midscan rd_en", int'(b0.rd_en), 0);
    check("midscan pix_valid", int'(b0.pix_valid), 0);
    check("midscan done", int'(done0), 0);
    repeat (N + 10) @(negedge clk);
    check("midscan no_done", done_cnt, 0);

    load(4);
    run_frame(-1, 1'b0, 1'b0, "after_reset");

`ifdef MEDIAN3X3_BYPASS_EN
    bypass = 1'b1;
    load(2);
    run_frame(-1, 1'b0, 1'b1, "bypass");
    ones = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) ones += int'(got[y][x]);
    check("bypass ones", ones, 9);
    bypass = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/median3x3_scan.md
Name: median3x3_scan

Overview:
- Downstream consumer of the padded binary event-image store.
- On `start`, reads the whole padded frame in raster order, one address per clock.
- Keeps two line buffers and a 3x3 window, and outputs one median-filtered pixel per clock for every unpadded image position.
- For binary data, median = majority: output 1 iff at least THRESH of the 9 window bits are 1. The result feeds the filtered-frame sink.

Parameters:
- IMWIDTH, 240, unpadded image width; padded width is IMWIDTH+2.
- IMHEIGHT, 180, unpadded image height; padded height is IMHEIGHT+2.
- THRESH, 5, minimum window popcount for a 1 output; 5 = true 3x3 median.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a frame scan; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until `done`.
- done  out  1  one-cycle pulse after the last output pixel.
- rd_en  out  1  read strobe to the image store; its write input is tied 0 during scan.
- rd_x  out  8  padded column address, 0..IMWIDTH+1.
- rd_y  out  8  padded row address, 0..IMHEIGHT+1.
- rd_data  in  1  store read data; valid exactly 1 cycle after the address.
- pix_valid  out  1  filtered pixel strobe.
- pix_x  out  8  unpadded column of output pixel, 0..IMWIDTH-1.
- pix_y  out  8  unpadded row of output pixel, 0..IMHEIGHT-1.
- pix_out  out  1  filtered pixel value.

Behaviour:
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - line buffers and window cleared to 0.
- FSM states and transitions:
  - IDLE: waits for `start`.
  - SCAN: entered on `start`. Drives `rd_en=1` with address k (raster order: x fastest, then y) in cycle k+1 after start, k = 0..N-1, where N = (IMWIDTH+2)*(IMHEIGHT+2) = 44044 at defaults. After the last address, goes to DRAIN.
  - DRAIN: `rd_en=0`. Waits 2 cycles for the last data to return and the last pixel to be emitted.
  - DONE: `done=1` and `busy=0` for one cycle, then IDLE.
- Data capture: a 1-cycle delayed copy of `rd_en`/`rd_x`/`rd_y` tags `rd_data` as padded coordinate (px,py).
- Line buffers (each IMWIDTH+2 bits): lb1 holds row py-2, lb0 holds row py-1. On each capture:
  - window shifts one column left;
  - new right column = {lb1[px], lb0[px], rd_data};
  - then lb1[px] <= lb0[px] and lb0[px] <= rd_data.
- Output rule: when the captured pixel has px>=2 and py>=2, then in the next cycle:
  - pix_valid=1;
  - pix_x=px-2, pix_y=py-2;
  - pix_out = (popcount(window incl. new column) >= THRESH).
  - Latency: address issue -> pix_valid = 2 cycles.
- Window contents are not cleared at row starts. Stale columns from the previous row are fully displaced before px reaches 2.
- Popcount is 4 bits wide, range 0..9; compared unsigned against THRESH.
- Exactly IMWIDTH*IMHEIGHT = 43200 pix_valid pulses per frame, in raster order, with no gaps once row output begins.
- Boundary conditions:
  - `start` while busy: ignored.
  - `start` and `reset` in the same cycle: reset wins.
  - Reset mid-scan: next cycle is IDLE; all outputs 0; no `done`; partial frame abandoned.
  - `start` asserted in the DONE cycle: ignored. A new start is accepted from IDLE only.
  - THRESH=0: every output is 1. THRESH>9: every output is 0.
- Store border cells (padded row/column 0 and IMWIDTH+1 / IMHEIGHT+1) are zero by store convention. This block reads them like any other cell and does not force them to 0.

Optional Feature:
- MEDIAN3X3_BYPASS_EN.
- When defined: adds input port `bypass` (1 bit), sampled each output cycle. With bypass=1, pix_out = window centre bit (the unfiltered pixel at pix_x,pix_y). Timing, strobes and count are unchanged.
- When undefined: no `bypass` port; pix_out is always the thresholded popcount.

Test Plan:
1. All-zero store, pulse start -> 43200 pix_valid, all pix_out=0; first pix_valid 2 cycles after address (2,2) issued; done 1 cycle after the last pixel; busy low with done.
2. Single 1 at padded (50,40) -> pix_out=0 everywhere (isolated event removed).
3. 3x3 block of 1s at padded x,y 10..12 -> pix_out=1 only at unpadded (10,10),(9,10),(11,10),(10,9),(10,11) (plus shape); corners of the block 0; all else 0.
4. Interior all 1s, border 0 -> unpadded corners (0,0),(239,0),(0,179),(239,179) pix_out=0 (popcount 4); other edge pixels 1 (popcount 6); interior 1.
5. Reset asserted 1000 cycles into scan -> next cycle busy=0, rd_en=0, pix_valid=0, no done. A new start then completes a full 43200-pixel frame correctly.
6. Start pulsed again while busy, and start asserted in the DONE cycle -> ignored; exactly one done per accepted start. With MEDIAN3X3_BYPASS_EN and bypass=1 on test 3's data -> output equals the raw 3x3 block.
